regfile_wb_arbiter: RTL

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_pkg.sv | 16 +
 rtl/rr_arb2.sv | 46 ++++
 rtl/regfile_wb_arbiter.sv | 73 +++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared widths and round-robin pointer encoding for the register-file writeback arbiter.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    typedef enum logic {
        PRIO_ALU = 1'b0,
        PRIO_MEM = 1'b1
    } prio_t;

    function automatic prio_t prio_other(input prio_t p);
        return (p == PRIO_ALU) ? PRIO_MEM : PRIO_ALU;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant (combinational grants, one-bit pointer register).
// Grants drop while blocked or in reset; the pointer only moves when both requesters contend.
module rr_arb2
    import regfile_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic i_req_alu,
    input  logic i_req_mem,
    input  logic i_block,
    output logic o_gnt_alu,
    output logic o_gnt_mem
);

    prio_t r_prio;
    prio_t w_prio_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prio <= PRIO_ALU;
        end else begin
            r_prio <= w_prio_nxt;
        end
    end

    always_comb begin
        o_gnt_alu  = 1'b0;
        o_gnt_mem  = 1'b0;
        w_prio_nxt = r_prio;
        if (!reset && !i_block) begin
            if (i_req_alu && i_req_mem) begin
                // Contention: serve the pointed-to side, then hand priority to the other.
                if (r_prio == PRIO_ALU) begin
                    o_gnt_alu = 1'b1;
                end else begin
                    o_gnt_mem = 1'b1;
                end
                w_prio_nxt = prio_other(r_prio);
            end else begin
                o_gnt_alu = i_req_alu;
                o_gnt_mem = i_req_mem;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU and load writebacks onto a single register-file write port.
// One-cycle registered write; wb_stall blocks new grants but never cancels a registered write.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_destadd,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_destadd,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    input  logic              wb_stall,
    output logic              wr_en,
    output logic [ADDR_W-1:0] destadd,
    output logic [DATA_W-1:0] wr_data,
    output logic              last_src
);

    logic              w_alu_gnt;
    logic              w_mem_gnt;
    logic [ADDR_W-1:0] w_sel_dest;
    logic [DATA_W-1:0] w_sel_data;

    logic              r_wr_en;
    logic [ADDR_W-1:0] r_destadd;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_last_src;

    rr_arb2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .i_req_alu (alu_valid),
        .i_req_mem (mem_valid),
        .i_block   (wb_stall),
        .o_gnt_alu (w_alu_gnt),
        .o_gnt_mem (w_mem_gnt)
    );

    assign alu_ready  = w_alu_gnt;
    assign mem_ready  = w_mem_gnt;
    assign w_sel_dest = w_mem_gnt ? mem_destadd : alu_destadd;
    assign w_sel_data = w_mem_gnt ? mem_data    : alu_data;

    // Address 0 is written like any other register; filtering is the register file's job.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_en    <= 1'b0;
            r_destadd  <= '0;
            r_wr_data  <= '0;
            r_last_src <= 1'b0;
        end else if (w_alu_gnt || w_mem_gnt) begin
            r_wr_en    <= 1'b1;
            r_destadd  <= w_sel_dest;
            r_wr_data  <= w_sel_data;
            r_last_src <= w_mem_gnt;
        end else begin
            r_wr_en    <= 1'b0;
        end
    end

    assign wr_en    = r_wr_en;
    assign destadd  = r_destadd;
    assign wr_data  = r_wr_data;
    assign last_src = r_last_src;

endmodule
